// File: rtl/ahb_mtx_pkg.sv
// Shared definitions for the AHB bus matrix: HTRANS/HBURST encodings,
// output-arbiter state type and the fixed-burst beat-count helper.
package ahb_mtx_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam int BEAT_CNT_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SINGLE = 2'd1,
        ARB_BURST  = 2'd2,
        ARB_LOCKED = 2'd3
    } arb_state_t;

    // Remaining SEQ beats after the NONSEQ of a fixed-length burst; 0 means
    // the transfer is not held (SINGLE or undefined-length INCR).
    function automatic logic [BEAT_CNT_W-1:0] burst_beats(input logic [2:0] hburst);
        logic [BEAT_CNT_W-1:0] beats;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  beats = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  beats = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
            HBURST_SINGLE, HBURST_INCR:   beats = 4'd0;
            default:                      beats = 4'd0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_mtx_l1_arb_pick.sv
// Combinational request picker: scans the request vector starting at the
// port after ptr and returns the first requester. Tying ptr to the highest
// index turns it into a fixed lowest-index-wins priority picker.
module ahb_mtx_l1_arb_pick #(
    parameter int NUM_PORTS = 3,
    parameter int PW        = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PW-1:0]        ptr,
    output logic [PW-1:0]        idx,
    output logic                 valid
);

    // First requester in rotating order after ptr.
    always_comb begin
        int j;
        j     = 0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            j = (int'(ptr) + k) % NUM_PORTS;
            if (!valid && req[j]) begin
                idx   = PW'(j);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_mtx_l1_arb_out.sv
// Output-stage arbiter of the level-1 AHB bus matrix. Grants the shared
// output port per address phase, holds it across fixed bursts and locked
// sequences, and tracks the data-phase owner.
// Build option: AHB_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// without it the lowest-index valid request wins.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ARB_IDLE   | no owner, output stage drives HTRANS=IDLE
// ARB_SINGLE | owner had one address phase; re-arbitrate at next boundary
// ARB_BURST  | fixed-length burst running, cnt_q = SEQ beats still due
// ARB_LOCKED | owner holds while its HMASTLOCK and select stay high
module ahb_mtx_l1_arb_out
    import ahb_mtx_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int PW        = 2
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_PORTS-1:0]   req_arb,
    input  logic [2*NUM_PORTS-1:0] trans_arb,
    input  logic [3*NUM_PORTS-1:0] burst_arb,
    input  logic [NUM_PORTS-1:0]   lock_arb,
    input  logic                   HREADYM,
    output logic [PW-1:0]          addr_in_port,
    output logic                   no_port,
    output logic [PW-1:0]          data_in_port,
    output logic [NUM_PORTS-1:0]   active_arb
);

    arb_state_t              state_q;
    logic [PW-1:0]           owner_q;
    logic [BEAT_CNT_W-1:0]   cnt_q;
    logic [PW-1:0]           ptr;

    logic [NUM_PORTS-1:0]    valid;
    logic                    own_req;
    logic                    own_lock;
    logic [1:0]              own_trans;
    logic                    release_own;
    logic                    arb_en;
    logic [PW-1:0]           pick_idx;
    logic                    pick_valid;
    logic                    win_lock;
    logic [BEAT_CNT_W-1:0]   win_beats;

    // A request only counts when the input stage presents a real transfer.
    always_comb begin
        valid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            valid[i] = req_arb[i] && (trans_arb[2*i +: 2] != HTRANS_IDLE);
        end
    end

    ahb_mtx_l1_arb_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PW        (PW)
    ) u_pick (
        .req   (valid),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

`ifdef AHB_ARB_ROUND_ROBIN_EN
    logic [PW-1:0] last_q;

    // Remember the last winner so the scan starts just after it.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            last_q <= PW'(NUM_PORTS - 1);
        end else if (arb_en && pick_valid) begin
            last_q <= pick_idx;
        end
    end

    assign ptr = last_q;
`else
    assign ptr = PW'(NUM_PORTS - 1);
`endif

    // Decide whether the current owner gives up the port this cycle. A
    // deselected owner is treated as presenting IDLE.
    always_comb begin
        own_req     = req_arb[owner_q];
        own_lock    = lock_arb[owner_q];
        own_trans   = own_req ? trans_arb[2*int'(owner_q) +: 2] : HTRANS_IDLE;
        release_own = 1'b1;
        case (state_q)
            ARB_BURST: begin
                case (own_trans)
                    HTRANS_SEQ:  release_own = (cnt_q <= 4'd1);
                    HTRANS_BUSY: release_own = 1'b0;
                    default:     release_own = 1'b1;
                endcase
            end
            ARB_LOCKED: release_own = !own_lock || !own_req;
            default:    release_own = 1'b1;
        endcase
        arb_en    = HREADYM && !HRESET && release_own;
        win_lock  = lock_arb[pick_idx];
        win_beats = burst_beats(burst_arb[3*int'(pick_idx) +: 3]);
    end

    // Zero-latency grant on arbitration cycles, otherwise hold the owner.
    always_comb begin
        if (arb_en) begin
            no_port      = !pick_valid;
            addr_in_port = pick_valid ? pick_idx : owner_q;
        end else begin
            no_port      = (state_q == ARB_IDLE);
            addr_in_port = owner_q;
        end
        active_arb = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            active_arb[i] = !no_port && (addr_in_port == PW'(i));
        end
    end

    // Ownership FSM and burst beat counter; lock outranks burst on a grant.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
        end else if (arb_en) begin
            if (pick_valid) begin
                owner_q <= pick_idx;
                if (win_lock) begin
                    state_q <= ARB_LOCKED;
                    cnt_q   <= '0;
                end else if (win_beats != '0) begin
                    state_q <= ARB_BURST;
                    cnt_q   <= win_beats;
                end else begin
                    state_q <= ARB_SINGLE;
                    cnt_q   <= '0;
                end
            end else begin
                state_q <= ARB_IDLE;
                cnt_q   <= '0;
            end
        end else if (HREADYM && state_q == ARB_BURST && own_trans == HTRANS_SEQ) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Data phase follows the address phase accepted at each ready edge.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            data_in_port <= '0;
        end else if (HREADYM && !no_port) begin
            data_in_port <= addr_in_port;
        end
    end

endmodule

// File: tb/tb_ahb_mtx_l1_arb_out.sv
// Directed bench for the output-stage arbiter; expected outputs are queued
// as each cycle is driven and popped when the DUT outputs are sampled.
module tb_ahb_mtx_l1_arb_out;

    localparam int N  = 3;
    localparam int PW = 2;

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
    localparam logic [2:0] B_SGL = 3'b000, B_INCR4 = 3'b011, B_WRAP8 = 3'b100,
                           B_INCR8 = 3'b101, B_INCR16 = 3'b111;

`ifdef AHB_ARB_ROUND_ROBIN_EN
    localparam logic [PW-1:0] LOCK_NEXT = 2'd1;
`else
    localparam logic [PW-1:0] LOCK_NEXT = 2'd0;
`endif

    logic            HCLK = 1'b0;
    logic            HRESET;
    logic [N-1:0]    req_arb;
    logic [2*N-1:0]  trans_arb;
    logic [3*N-1:0]  burst_arb;
    logic [N-1:0]    lock_arb;
    logic            HREADYM;
    logic [PW-1:0]   addr_in_port;
    logic            no_port;
    logic [PW-1:0]   data_in_port;
    logic [N-1:0]    active_arb;

    typedef struct packed {
        logic [PW-1:0] addr;
        logic          ca;
        logic          nop;
        logic [PW-1:0] data;
        logic [N-1:0]  act;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [PW-1:0] exp_data = '0;

    ahb_mtx_l1_arb_out #(.NUM_PORTS(N), .PW(PW)) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .req_arb      (req_arb),
        .trans_arb    (trans_arb),
        .burst_arb    (burst_arb),
        .lock_arb     (lock_arb),
        .HREADYM      (HREADYM),
        .addr_in_port (addr_in_port),
        .no_port      (no_port),
        .data_in_port (data_in_port),
        .active_arb   (active_arb)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic setp(input int p, input logic r, input logic [1:0] t,
                        input logic [2:0] b, input logic l);
        req_arb[p]          = r;
        trans_arb[2*p +: 2] = t;
        burst_arb[3*p +: 3] = b;
        lock_arb[p]         = l;
    endtask

    task automatic idle_all();
        for (int p = 0; p < N; p++) setp(p, 1'b0, T_IDLE, B_SGL, 1'b0);
    endtask

    task automatic push_exp(input logic enop, input logic [PW-1:0] eaddr, input logic ca);
        exp_t e;
        e.nop  = enop;
        e.addr = eaddr;
        e.ca   = ca;
        e.data = exp_data;
        e.act  = enop ? '0 : (N'(1) << eaddr);
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (no_port === e.nop) else begin
            errors++;
            $error("FAIL %s no_port got %b exp %b", tag, no_port, e.nop);
        end
        if (e.ca) begin
            checks++;
            assert (addr_in_port === e.addr) else begin
                errors++;
                $error("FAIL %s addr_in_port got %0d exp %0d", tag, addr_in_port, e.addr);
            end
        end
        checks++;
        assert (active_arb === e.act) else begin
            errors++;
            $error("FAIL %s active_arb got %b exp %b", tag, active_arb, e.act);
        end
        checks++;
        assert (data_in_port === e.data) else begin
            errors++;
            $error("FAIL %s data_in_port got %0d exp %0d", tag, data_in_port, e.data);
        end
    endtask

    // One bus cycle: inputs already driven, sample mid-cycle, then clock.
    task automatic cyc(input logic hr, input logic enop, input logic [PW-1:0] eaddr,
                       input string tag);
        HREADYM = hr;
        push_exp(enop, eaddr, !enop);
        @(negedge HCLK);
        check_out(tag);
        if (hr && !enop) exp_data = eaddr;
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESET  = 1'b1;
        HREADYM = 1'b1;
        idle_all();
        #3;
        push_exp(1'b1, 2'd0, 1'b1);
        check_out("reset");
        #9;
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;

        // Idle, then two single requesters
        cyc(1'b1, 1'b1, 2'd0, "idle");
        setp(0, 1'b1, T_NSEQ, B_SGL, 1'b0);
        setp(2, 1'b1, T_NSEQ, B_SGL, 1'b0);
        cyc(1'b1, 1'b0, 2'd0, "single_p0");
        setp(0, 1'b0, T_IDLE, B_SGL, 1'b0);
        cyc(1'b1, 1'b0, 2'd2, "single_p2");
        idle_all();
        cyc(1'b1, 1'b1, 2'd0, "single_done");
        cyc(1'b1, 1'b1, 2'd0, "idle_hold_data");

        // INCR4 on port 1 with port 0 waiting
        setp(1, 1'b1, T_NSEQ, B_INCR4, 1'b0);
        cyc(1'b1, 1'b0, 2'd1, "incr4_nseq");
        setp(0, 1'b1, T_NSEQ, B_SGL, 1'b0);
        setp(1, 1'b1, T_SEQ, B_INCR4, 1'b0);
        cyc(1'b1, 1'b0, 2'd1, "incr4_b2");
        cyc(1'b1, 1'b0, 2'd1, "incr4_b3");
        cyc(1'b1, 1'b0, 2'd0, "incr4_b4_handover");
        idle_all();
        cyc(1'b1, 1'b1, 2'd0, "incr4_after");

        // WRAP8 on port 1 with BUSY beats and a wait-state stretch
        setp(1, 1'b1, T_NSEQ, B_WRAP8, 1'b0);
        cyc(1'b1, 1'b0, 2'd1, "wrap8_nseq");
        setp(0, 1'b1, T_NSEQ, B_SGL, 1'b0);
        setp(1, 1'b1, T_SEQ, B_WRAP8, 1'b0);
        cyc(1'b1, 1'b0, 2'd1, "wrap8_s1");
        setp(1, 1'b1, T_BUSY, B_WRAP8, 1'b0);
        cyc(1'b1, 1'b0, 2'd1, "wrap8_busy1");
        setp(1, 1'b1, T_SEQ, B_WRAP8, 1'b0);
        cyc(1'b1, 1'b0, 2'd1, "wrap8_s2");
        setp(2, 1'b1, T_NSEQ, B_SGL, 1'b0);
        cyc(1'b0, 1'b0, 2'd1, "wrap8_wait1");
        setp(0, 1'b0, T_IDLE, B_SGL, 1'b0);
        cyc(1'b0, 1'b0, 2'd1, "wrap8_wait2");
        setp(0, 1'b1, T_NSEQ, B_SGL, 1'b0);
        cyc(1'b0, 1'b0, 2'd1, "wrap8_wait3");
        setp(2, 1'b0, T_IDLE, B_SGL, 1'b0);
        cyc(1'b1, 1'b0, 2'd1, "wrap8_s3");
        setp(1, 1'b1, T_BUSY, B_WRAP8, 1'b0);
        cyc(1'b1, 1'b0, 2'd1, "wrap8_busy2");
        setp(1, 1'b1, T_SEQ, B_WRAP8, 1'b0);
        cyc(1'b1, 1'b0, 2'd1, "wrap8_s4");
        cyc(1'b1, 1'b0, 2'd1, "wrap8_s5");
        cyc(1'b1, 1'b0, 2'd1, "wrap8_s6");
        cyc(1'b1, 1'b0, 2'd0, "wrap8_s7_handover");
        idle_all();
        cyc(1'b1, 1'b1, 2'd0, "wrap8_after");

        // INCR8 on port 2 terminated early by IDLE
        setp(2, 1'b1, T_NSEQ, B_INCR8, 1'b0);
        cyc(1'b1, 1'b0, 2'd2, "incr8_nseq");
        setp(0, 1'b1, T_NSEQ, B_SGL, 1'b0);
        setp(2, 1'b1, T_SEQ, B_INCR8, 1'b0);
        cyc(1'b1, 1'b0, 2'd2, "incr8_s1");
        cyc(1'b1, 1'b0, 2'd2, "incr8_s2");
        setp(2, 1'b1, T_IDLE, B_INCR8, 1'b0);
        cyc(1'b1, 1'b0, 2'd0, "incr8_early_end");
        idle_all();
        cyc(1'b1, 1'b1, 2'd0, "incr8_after");

        // Locked sequence on port 0, lock outranks its burst encoding
        setp(0, 1'b1, T_NSEQ, B_INCR4, 1'b1);
        cyc(1'b1, 1'b0, 2'd0, "lock_t1");
        setp(0, 1'b1, T_SEQ, B_INCR4, 1'b1);
        setp(1, 1'b1, T_NSEQ, B_SGL, 1'b0);
        setp(2, 1'b1, T_NSEQ, B_SGL, 1'b0);
        cyc(1'b1, 1'b0, 2'd0, "lock_t2");
        setp(0, 1'b1, T_NSEQ, B_INCR4, 1'b1);
        cyc(1'b1, 1'b0, 2'd0, "lock_t3");
        setp(0, 1'b1, T_NSEQ, B_SGL, 1'b0);
        cyc(1'b1, 1'b0, LOCK_NEXT, "lock_release");
        idle_all();
        cyc(1'b1, 1'b1, 2'd0, "lock_after");

        // INCR16 on port 1 interrupted by reset
        setp(1, 1'b1, T_NSEQ, B_INCR16, 1'b0);
        cyc(1'b1, 1'b0, 2'd1, "incr16_nseq");
        setp(1, 1'b1, T_SEQ, B_INCR16, 1'b0);
        cyc(1'b1, 1'b0, 2'd1, "incr16_s1");
        setp(0, 1'b1, T_NSEQ, B_SGL, 1'b0);
        setp(2, 1'b1, T_NSEQ, B_SGL, 1'b0);
        cyc(1'b1, 1'b0, 2'd1, "incr16_s2");
        HRESET = 1'b1;
        #2;
        exp_data = '0;
        push_exp(1'b1, 2'd0, 1'b1);
        check_out("reset_async");
        setp(1, 1'b1, T_NSEQ, B_INCR16, 1'b0);
        #1;
        HRESET = 1'b0;
        cyc(1'b1, 1'b0, 2'd0, "post_reset_p0");
        setp(0, 1'b0, T_IDLE, B_SGL, 1'b0);
        cyc(1'b1, 1'b0, 2'd1, "post_reset_p1");
        idle_all();
        cyc(1'b1, 1'b1, 2'd0, "post_reset_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_mtx_l1_arb_out.md
# ahb_mtx_l1_arb_out

Output-stage arbiter for the level-1 AHB bus matrix. It decides which input stage owns a shared output port: the per-output-port decoders deliver one select per input port, and the arbiter grants the port for each address phase. A grant is held across fixed-length bursts and locked sequences, and the arbiter tracks which input port owns the data phase. It drives the output-stage address and data multiplexers and the `active` feedback returned to each decoder.

## Interface
- `NUM_PORTS`, 3: number of input stages sharing this output port (2..8).
- `PW`, 2: port index width, equal to `$clog2(NUM_PORTS)`.
- `HCLK`  in  1  AHB system clock.
- `HRESET`  in  1  asynchronous, active-high reset.
- `req_arb`  in  NUM_PORTS  per-input select from the decoders (`sel_decN` for this port), already qualified by the input-stage HSEL.
- `trans_arb`  in  2*NUM_PORTS  per-input HTRANS; port i occupies bits [2i+1:2i].
- `burst_arb`  in  3*NUM_PORTS  per-input HBURST; port i occupies bits [3i+2:3i].
- `lock_arb`  in  NUM_PORTS  per-input HMASTLOCK.
- `HREADYM`  in  1  HREADY of the output port; it marks the transfer boundary.
- `addr_in_port`  out  PW  input port whose signals drive the address phase.
- `no_port`  out  1  no owner; the output stage drives HTRANS=IDLE.
- `data_in_port`  out  PW  input port that owns the current data phase.
- `active_arb`  out  NUM_PORTS  one-hot; bit i high means port i owns the address phase (the `active_decN` source).

## Operation
- A request is valid when `req_arb[i]` is high and `trans_arb[i]` is not IDLE (2'b00).
- FSM states:
  - IDLE: no owner, `no_port`=1.
  - SINGLE: owner holds for one address phase.
  - BURST: fixed-length burst in progress; the owner holds.
  - LOCKED: owner holds while its lock is high.
- Arbitration happens only in a cycle with `HREADYM`=1 whose state is IDLE or SINGLE, or a BURST or LOCKED state that is releasing. In every other cycle the owner and all outputs are held.
- On a grant, the next state is chosen by the winner's signals:
  - `lock_arb`=1 → LOCKED.
  - Otherwise, HBURST of INCR4/WRAP4, INCR8/WRAP8 or INCR16/WRAP16 → BURST, with the beat counter loaded to 3, 7 or 15.
  - Otherwise → SINGLE.
  - No valid request → IDLE.
- BURST beat counting: each SEQ accepted with `HREADYM`=1 decrements the counter. BUSY does not decrement. The burst releases when an accepted SEQ finds the counter at 1 (the last beat), or when the owner presents IDLE or NONSEQ (early termination).
- LOCKED releases on the first `HREADYM`=1 cycle in which the owner's lock is 0 or its request drops.
- Selection order: round-robin, starting from the port after the last granted port.
- Data-phase tracking: `data_in_port` loads `addr_in_port` on every `HREADYM`=1 edge. During IDLE it keeps its previous value.
- `active_arb` is the one-hot form of `addr_in_port`, gated by `!no_port`.

## Timing
- Reset values:
  - Outputs: `no_port`=1, `addr_in_port`=0, `data_in_port`=0, `active_arb`=0.
  - Internal: state IDLE, counter 0, last-granted pointer NUM_PORTS-1 (so port 0 wins first).
- Grant latency is zero cycles: `addr_in_port`, `no_port` and `active_arb` are combinational from the registered state and the current requests. The state and the pointer register on `HCLK`.
- `data_in_port` lags `addr_in_port` by exactly one accepted transfer.
- With `HREADYM` low, no register changes and the outputs stay stable even if requests change.
- Simultaneous release and new requests resolve in the same cycle: the last beat is accepted and the next owner is granted in that cycle.
- A locked owner that raises a fixed burst stays in LOCKED. Lock has precedence over burst.
- An `HRESET` assertion at any point, including mid-burst, returns all state to the reset values immediately and asynchronously.

## Configuration
- `AHB_ARB_ROUND_ROBIN_EN`:
  - Defined: round-robin as described above.
  - Undefined: fixed priority, lowest index wins. The last-granted pointer is not implemented, and burst and lock holding are unchanged.

## Structure
- Shared package `ahb_mtx_pkg` holds:
  - the HTRANS encodings IDLE/BUSY/NONSEQ/SEQ;
  - the HBURST encodings;
  - the FSM state typedef;
  - a `burst_beats(hburst)` function that returns the counter load value.
- One sub-module, `ahb_mtx_l1_arb_pick`: a combinational round-robin/priority picker (request vector and pointer in; index and valid out). It is reused by the other output ports.

## Test plan
- Reset, then all requests 0 → `no_port`=1, `active_arb`=0. Then port 0 and port 2 request NONSEQ SINGLE → port 0 granted, next boundary port 2, `data_in_port` following one transfer later.
- Port 1 issues INCR4 (NONSEQ, SEQ×3) with port 0 requesting throughout → port 1 holds for 4 beats, port 0 is granted in the cycle the 4th beat is accepted.
- Port 1 issues WRAP8 with two BUSY cycles and `HREADYM` low for 3 cycles mid-burst → the counter freezes, the grant and `data_in_port` are stable, and the burst releases after the 8th SEQ-accepted beat.
- Port 2 issues INCR8, then IDLE after 3 beats → early release, and the waiting port 0 is granted that cycle.
- Port 0 locked for 3 transfers while ports 1 and 2 request → both are blocked until lock=0. Round-robin then grants port 1; without the macro it grants port 0 again.
- Assert `HRESET` mid INCR16 → outputs return to their reset values without waiting for a clock, and the first grant after release goes to port 0.
